// File: rtl/clock_freq_meter.sv
// Gated frequency meter: counts a fixed local-clock window, latches the upstream
// counters and divides (extern * LOCAL_FREQ_HZ) / local with a bit-serial divider.
module clock_freq_meter #(
  parameter int unsigned CLOCK_COUNTER_WIDTH = 64,
  parameter logic [31:0] LOCAL_FREQ_HZ       = 32'd100_000_000,
  parameter int unsigned GATE_CYCLES         = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES      = 4_000_000,
  parameter int unsigned RESULT_WIDTH        = 32
) (
  input  logic                           i_clk_local,
  input  logic                           i_rst_n,
  input  logic                           i_enable,
  output logic                           o_latch_counters,
  input  logic                           i_counter_valid,
  input  logic [CLOCK_COUNTER_WIDTH-1:0] i_clk_local_counter,
  input  logic [CLOCK_COUNTER_WIDTH-1:0] i_clk_extern_counter,
  output logic                           o_freq_valid,
  input  logic                           i_freq_ready,
  output logic [RESULT_WIDTH-1:0]        o_freq_hz,
  output logic                           o_saturated,
  output logic                           o_div_zero,
  output logic                           o_timeout
);

  localparam int unsigned PW  = CLOCK_COUNTER_WIDTH + 32;
  localparam int unsigned DW  = CLOCK_COUNTER_WIDTH + RESULT_WIDTH;
  localparam int unsigned MW  = (PW > DW) ? PW : DW;
  localparam int unsigned GCW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned DCW = (RESULT_WIDTH > 1) ? $clog2(RESULT_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, GATE, LATCH, WAIT_DROP, WAIT_VALID, DIVIDE, OUTPUT, TIMEOUT
  } state_t;

  function automatic logic [MW-1:0] full_product(input logic [CLOCK_COUNTER_WIDTH-1:0] ext);
    return MW'(ext) * MW'(LOCAL_FREQ_HZ);
  endfunction

  // Quotient overflows RESULT_WIDTH exactly when P >= local << RESULT_WIDTH.
  function automatic logic quotient_saturates(input logic [MW-1:0] p,
                                              input logic [CLOCK_COUNTER_WIDTH-1:0] loc);
    return p >= (MW'(loc) << RESULT_WIDTH);
  endfunction

  function automatic logic [MW:0] trial_subtract(input logic [MW-1:0] rem,
                                                 input logic [MW-1:0] dsr);
    return {1'b0, rem} - {1'b0, dsr};
  endfunction

  // Asynchronous assert, synchronised release.
  logic [1:0] rst_sync;
  logic       rst_n_sync;

  always_ff @(posedge i_clk_local or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_sync = rst_sync[1];

  state_t                  state;
  logic [GCW-1:0]          gate_cnt;
  logic [TCW-1:0]          tmo_cnt;
  logic [DCW-1:0]          div_cnt;
  logic [MW-1:0]           rem_p1;
  logic [MW-1:0]           dsr_p1;
  logic [RESULT_WIDTH-1:0] quot_p1;

  logic [MW-1:0]           prod_c;
  logic                    capture_c;
  logic                    loc_zero_c;
  logic                    sat_c;
  logic                    tmo_done_c;
  logic [MW:0]             trial_c;
  logic                    q_bit_c;
  logic [RESULT_WIDTH-1:0] quot_next_c;

  assign prod_c      = full_product(i_clk_extern_counter);
  assign capture_c   = (state == WAIT_VALID) && i_counter_valid && i_enable;
  assign loc_zero_c  = (i_clk_local_counter == '0);
  assign sat_c       = quotient_saturates(prod_c, i_clk_local_counter);
  assign tmo_done_c  = (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));
  assign trial_c     = trial_subtract(rem_p1, dsr_p1);
  assign q_bit_c     = ~trial_c[MW];
  assign quot_next_c = {quot_p1[RESULT_WIDTH-2:0], q_bit_c};

  // Capture -> divider: restoring division against a right-shifting divisor,
  // one quotient bit per cycle, MSB first.
  always_ff @(posedge i_clk_local) begin
    if (capture_c) begin
      rem_p1 <= prod_c;
      dsr_p1 <= MW'(i_clk_local_counter) << (RESULT_WIDTH - 1);
    end else if (state == DIVIDE) begin
      if (q_bit_c) rem_p1 <= trial_c[MW-1:0];
      dsr_p1  <= dsr_p1 >> 1;
      quot_p1 <= quot_next_c;
    end
  end

  always_ff @(posedge i_clk_local or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state            <= IDLE;
      gate_cnt         <= '0;
      tmo_cnt          <= '0;
      div_cnt          <= '0;
      o_latch_counters <= 1'b0;
      o_freq_valid     <= 1'b0;
      o_freq_hz        <= '0;
      o_saturated      <= 1'b0;
      o_div_zero       <= 1'b0;
      o_timeout        <= 1'b0;
    end else begin
      o_latch_counters <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable && i_counter_valid) begin
            state    <= GATE;
            gate_cnt <= '0;
          end
        end
        GATE: begin
          if (!i_enable) begin
            state <= IDLE;
          end else if (gate_cnt == GCW'(GATE_CYCLES - 1)) begin
            state            <= LATCH;
            o_latch_counters <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        LATCH: begin
          tmo_cnt <= '0;
          state   <= i_enable ? WAIT_DROP : IDLE;
        end
        // The wait states ignore i_enable until upstream has completed its cycle.
        WAIT_DROP: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!i_counter_valid) begin
            state <= WAIT_VALID;
          end else if (tmo_done_c) begin
            state     <= TIMEOUT;
            o_timeout <= 1'b1;
          end
        end
        WAIT_VALID: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (i_counter_valid) begin
            if (!i_enable) begin
              state <= IDLE;
            end else begin
              o_timeout <= 1'b0;
              div_cnt   <= '0;
              if (loc_zero_c) begin
                o_freq_hz    <= '1;
                o_div_zero   <= 1'b1;
                o_saturated  <= 1'b0;
                o_freq_valid <= 1'b1;
                state        <= OUTPUT;
              end else if (sat_c) begin
                o_freq_hz    <= '1;
                o_div_zero   <= 1'b0;
                o_saturated  <= 1'b1;
                o_freq_valid <= 1'b1;
                state        <= OUTPUT;
              end else begin
                state <= DIVIDE;
              end
            end
          end else if (tmo_done_c) begin
            state     <= TIMEOUT;
            o_timeout <= 1'b1;
          end
        end
        DIVIDE: begin
          if (!i_enable) begin
            state <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == DCW'(RESULT_WIDTH - 1)) begin
              o_freq_hz    <= quot_next_c;
              o_div_zero   <= 1'b0;
              o_saturated  <= 1'b0;
              o_freq_valid <= 1'b1;
              state        <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (!i_enable) begin
            o_freq_valid <= 1'b0;
            state        <= IDLE;
          end else if (i_freq_ready) begin
            o_freq_valid <= 1'b0;
            gate_cnt     <= '0;
            state        <= GATE;
          end
        end
        TIMEOUT: begin
          if (!i_enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_freq_meter.sv
// Randomised bench for clock_freq_meter with an arithmetic reference model
// of the frequency result, its flags and its handshake timing.
module tb_clock_freq_meter;

  localparam int          CW    = 64;
  localparam int          RW    = 32;
  localparam logic [31:0] LOCAL = 32'd100_000_000;
  localparam int          GATE  = 10;
  localparam int          TMO   = 50;

  logic           clk = 1'b0;
  logic           i_rst_n;
  logic           i_enable;
  logic           o_latch_counters;
  logic           i_counter_valid;
  logic [CW-1:0]  i_clk_local_counter;
  logic [CW-1:0]  i_clk_extern_counter;
  logic           o_freq_valid;
  logic           i_freq_ready;
  logic [RW-1:0]  o_freq_hz;
  logic           o_saturated;
  logic           o_div_zero;
  logic           o_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int latch_cnt = 0;
  int valid_seen = 0;

  always #5 clk = ~clk;

  clock_freq_meter #(
    .CLOCK_COUNTER_WIDTH(CW),
    .LOCAL_FREQ_HZ      (LOCAL),
    .GATE_CYCLES        (GATE),
    .TIMEOUT_CYCLES     (TMO),
    .RESULT_WIDTH       (RW)
  ) dut (
    .i_clk_local         (clk),
    .i_rst_n             (i_rst_n),
    .i_enable            (i_enable),
    .o_latch_counters    (o_latch_counters),
    .i_counter_valid     (i_counter_valid),
    .i_clk_local_counter (i_clk_local_counter),
    .i_clk_extern_counter(i_clk_extern_counter),
    .o_freq_valid        (o_freq_valid),
    .i_freq_ready        (i_freq_ready),
    .o_freq_hz           (o_freq_hz),
    .o_saturated         (o_saturated),
    .o_div_zero          (o_div_zero),
    .o_timeout           (o_timeout)
  );

  always @(negedge clk) begin
    if (o_latch_counters) latch_cnt++;
    if (o_freq_valid) valid_seen++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: exact quotient at 128 bits, then classify.
  task automatic ref_model(input logic [63:0] ext, input logic [63:0] loc,
                           output logic [31:0] hz, output logic sat, output logic dz);
    logic [127:0] p;
    logic [127:0] q;
    p   = {64'd0, ext} * {96'd0, LOCAL};
    sat = 1'b0;
    dz  = 1'b0;
    if (loc == 64'd0) begin
      hz = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else begin
      q = p / {64'd0, loc};
      if (q > 128'hFFFF_FFFF) begin
        hz  = 32'hFFFF_FFFF;
        sat = 1'b1;
      end else begin
        hz = q[31:0];
      end
    end
  endtask

  task automatic wait_latch(input int gap);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_latch_counters && n < gap + 20);
    check("latch_gap", 64'(n), 64'(gap));
  endtask

  // Upstream behaviour: valid drops after the latch pulse, returns with counts.
  task automatic drop_and_return(input logic [63:0] ext, input logic [63:0] loc, input int drop);
    i_counter_valid = 1'b0;
    for (int j = 0; j < drop; j++) begin
      @(negedge clk);
      if (j == 0) check("latch_width", 64'(o_latch_counters), 64'd0);
    end
    i_clk_extern_counter = ext;
    i_clk_local_counter  = loc;
    i_counter_valid      = 1'b1;
  endtask

  task automatic run_measure(input logic [63:0] ext, input logic [63:0] loc, input int gap,
                             input int hold, input bit abort_out);
    logic [31:0] e_hz;
    logic        e_sat;
    logic        e_dz;
    logic [31:0] hz0;
    int          e_lat;
    int          n;
    int          h;
    bit          stable;
    ref_model(ext, loc, e_hz, e_sat, e_dz);
    e_lat = (e_sat || e_dz) ? 1 : RW + 1;
    wait_latch(gap);
    drop_and_return(ext, loc, 2 + int'($urandom_range(0, 4)));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_freq_valid && n < RW + 10);
    check("result_latency", 64'(n), 64'(e_lat));
    check("freq_hz", 64'(o_freq_hz), 64'(e_hz));
    check("saturated", 64'(o_saturated), 64'(e_sat));
    check("div_zero", 64'(o_div_zero), 64'(e_dz));
    check("timeout_clear", 64'(o_timeout), 64'd0);
    hz0    = o_freq_hz;
    stable = 1'b1;
    h      = (hold < 0) ? int'($urandom_range(0, 5)) : hold;
    repeat (h) begin
      @(negedge clk);
      if (!o_freq_valid || o_freq_hz !== hz0 || o_saturated !== e_sat ||
          o_div_zero !== e_dz || o_latch_counters) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    if (abort_out) i_enable = 1'b0;
    else           i_freq_ready = 1'b1;
    @(negedge clk);
    check("valid_clear", 64'(o_freq_valid), 64'd0);
    i_freq_ready = 1'b0;
  endtask

  task automatic rand_vec(output logic [63:0] ext, output logic [63:0] loc);
    int cat;
    cat = int'($urandom_range(0, 2));
    if (cat == 0) begin
      loc = 64'($urandom_range(1, 1 << 20));
      ext = 64'($urandom_range(0, 42 * int'(loc)));
    end else if (cat == 1) begin
      loc = {$urandom, $urandom};
      ext = {$urandom, $urandom};
    end else begin
      loc = 64'($urandom_range(1, 10));
      ext = {32'd0, $urandom};
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] ext;
    logic [63:0] loc;
    int          vs;
    int          ls;
    int          n;

    i_rst_n = 1'b0;
    i_enable = 1'b0;
    i_counter_valid = 1'b1;
    i_freq_ready = 1'b0;
    i_clk_local_counter = '0;
    i_clk_extern_counter = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {o_latch_counters, o_freq_valid, o_saturated, o_div_zero,
                            o_timeout, o_freq_hz}, 64'd0);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("post_release_outputs", {o_latch_counters, o_freq_valid, o_saturated, o_div_zero,
                                   o_timeout, o_freq_hz}, 64'd0);
    repeat (3) @(negedge clk);

    // Directed values, then randomised ones
    i_enable = 1'b1;
    run_measure(64'd1250, 64'd1000, GATE + 1, 3, 1'b0);
    run_measure(64'd5, 64'd0, GATE, -1, 1'b0);
    run_measure(64'd100, 64'd1, GATE, -1, 1'b0);
    run_measure(64'd16777216, 64'd390625, GATE, -1, 1'b0);
    run_measure(64'd16777215, 64'd390625, GATE, 20, 1'b0);
    run_measure(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, GATE, -1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rand_vec(ext, loc);
      run_measure(ext, loc, GATE, -1, 1'b0);
    end
    rand_vec(ext, loc);
    run_measure(ext, loc, GATE, 2, 1'b1);

    // Enable dropped mid-gate
    i_enable = 1'b1;
    repeat (5) @(negedge clk);
    i_enable = 1'b0;
    ls = latch_cnt;
    repeat (30) @(negedge clk);
    check("gate_abort_no_latch", 64'(latch_cnt - ls), 64'd0);

    // Enable dropped while waiting for upstream valid
    i_enable = 1'b1;
    wait_latch(GATE + 1);
    i_counter_valid = 1'b0;
    repeat (2) @(negedge clk);
    i_enable = 1'b0;
    vs = valid_seen;
    ls = latch_cnt;
    repeat (10) @(negedge clk);
    i_clk_extern_counter = 64'd1250;
    i_clk_local_counter  = 64'd1000;
    i_counter_valid      = 1'b1;
    repeat (40) @(negedge clk);
    check("wait_abort_no_result", 64'(valid_seen - vs), 64'd0);
    check("wait_abort_no_latch", 64'(latch_cnt - ls), 64'd0);
    i_enable = 1'b1;
    run_measure(64'd3000, 64'd7, GATE + 1, -1, 1'b0);

    // Upstream never returns valid
    wait_latch(GATE);
    i_counter_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_timeout && n < TMO + 20);
    check("timeout_latency", 64'(n), 64'(TMO + 1));
    ls = latch_cnt;
    repeat (20) @(negedge clk);
    check("timeout_no_latch", 64'(latch_cnt - ls), 64'd0);
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("timeout_sticky", 64'(o_timeout), 64'd1);
    i_counter_valid = 1'b1;
    i_enable = 1'b1;
    run_measure(64'd1250, 64'd1000, GATE + 1, -1, 1'b0);

    // Reset in the middle of a division
    wait_latch(GATE);
    drop_and_return(64'd1250, 64'd1000, 2);
    repeat (5) @(negedge clk);
    i_rst_n  = 1'b0;
    i_enable = 1'b0;
    vs = valid_seen;
    @(negedge clk);
    check("reset_mid_divide_outputs", {o_latch_counters, o_freq_valid, o_saturated, o_div_zero,
                                       o_timeout, o_freq_hz}, 64'd0);
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("reset_discard_result", 64'(valid_seen - vs), 64'd0);
    i_enable = 1'b1;
    rand_vec(ext, loc);
    run_measure(ext, loc, GATE + 1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_freq_meter.md
CLOCK_FREQ_METER -- requirements
Module: clock_freq_meter

Interface
REQ-001 Parameter CLOCK_COUNTER_WIDTH, default 64, SHALL be the width of the upstream counter inputs.
REQ-002 Parameter LOCAL_FREQ_HZ, default 100_000_000, 32 bits, SHALL be the nominal i_clk_local frequency.
REQ-003 Parameter GATE_CYCLES, default 1_000_000, SHALL be the number of i_clk_local cycles per measurement window.
REQ-004 Parameter TIMEOUT_CYCLES, default 4_000_000, SHALL be the maximum wait for upstream counter valid.
REQ-005 Parameter RESULT_WIDTH, default 32, SHALL be the width of the frequency result.
REQ-006 i_clk_local  in  1  SHALL be the local clock; all logic is synchronous to it.
REQ-007 i_rst_n  in  1  SHALL be the reset, asynchronous, active-low.
REQ-008 i_enable  in  1  SHALL start measurements while high and return the block to IDLE when low.
REQ-009 o_latch_counters  out  1  SHALL be the one-cycle latch pulse to the upstream clock counter.
REQ-010 i_counter_valid  in  1  SHALL be the upstream counter-valid flag.
REQ-011 i_clk_local_counter  in  CLOCK_COUNTER_WIDTH  SHALL be the upstream local count.
REQ-012 i_clk_extern_counter  in  CLOCK_COUNTER_WIDTH  SHALL be the upstream external count.
REQ-013 o_freq_valid / i_freq_ready  out/in  1/1  SHALL form the result handshake.
REQ-014 o_freq_hz  out  RESULT_WIDTH  SHALL be the measured external frequency in Hz.
REQ-015 o_saturated, o_div_zero, o_timeout  out  1 each  SHALL be the result and status flags.

Function
REQ-016 The FSM SHALL have states IDLE, GATE, LATCH, WAIT_DROP, WAIT_VALID, DIVIDE, OUTPUT and TIMEOUT.
REQ-017 IDLE SHALL move to GATE when i_enable=1 and i_counter_valid=1; the gate counter SHALL clear on GATE entry.
REQ-018 GATE SHALL count exactly GATE_CYCLES cycles, then move to LATCH.
REQ-019 LATCH SHALL assert o_latch_counters for exactly one cycle, then move to WAIT_DROP.
REQ-020 WAIT_DROP SHALL wait for i_counter_valid=0, because upstream valid drops one cycle after the latch.
REQ-021 WAIT_VALID SHALL wait for i_counter_valid=1, then capture both counts and move to DIVIDE.
REQ-022 On capture, the product P SHALL be i_clk_extern_counter * LOCAL_FREQ_HZ at full CLOCK_COUNTER_WIDTH+32 width, with no truncation.
REQ-023 If the captured local count is 0, the block SHALL skip the division and set o_freq_hz to all-ones and o_div_zero to 1.
REQ-024 If P >= (local << RESULT_WIDTH), the block SHALL skip the division and set o_freq_hz to all-ones and o_saturated to 1.
REQ-025 Otherwise DIVIDE SHALL run restoring division for exactly RESULT_WIDTH cycles, one quotient bit per cycle, MSB first, producing floor(P/local).
REQ-026 In the non-skipped case, o_freq_valid SHALL rise RESULT_WIDTH+1 cycles after the capture cycle; in the skipped cases it SHALL rise 1 cycle after capture.
REQ-027 In OUTPUT, o_freq_hz and the flags SHALL hold stable while o_freq_valid=1 and i_freq_ready=0.
REQ-028 The transfer SHALL occur on the cycle where o_freq_valid=1 and i_freq_ready=1.
REQ-029 After a transfer, o_freq_valid SHALL clear next cycle and the FSM SHALL return to GATE if i_enable=1, else to IDLE.
REQ-030 o_saturated and o_div_zero SHALL describe only the current result.
REQ-031 A timeout counter SHALL run in WAIT_DROP and WAIT_VALID; on reaching TIMEOUT_CYCLES the FSM SHALL enter TIMEOUT and set o_timeout.
REQ-032 The block SHALL stay in TIMEOUT until i_enable=0, then go to IDLE; o_timeout SHALL stay set until the next successful capture.
REQ-033 If i_enable=0 in any state except WAIT_DROP or WAIT_VALID, the block SHALL abort next cycle to IDLE and clear o_freq_valid.
REQ-034 WAIT_DROP and WAIT_VALID SHALL finish their upstream handshake before honouring i_enable=0, so upstream is not left mid-latch.
REQ-035 o_latch_counters SHALL never assert outside LATCH.

Reset
REQ-036 While i_rst_n=0, the FSM SHALL be in IDLE and o_latch_counters, o_freq_valid, o_saturated, o_div_zero, o_timeout and o_freq_hz SHALL all be 0.
REQ-037 Release of i_rst_n SHALL be synchronised to i_clk_local, and no output SHALL change in the first cycle after release.
REQ-038 Reset asserted mid-DIVIDE or mid-OUTPUT SHALL discard the result with no o_freq_valid pulse.

Verification
REQ-039 With LOCAL_FREQ_HZ=100_000_000, local=1000 and extern=1250 -> o_freq_hz=125_000_000, flags 0, valid 33 cycles after capture (RESULT_WIDTH=32).
REQ-040 With local=0 -> o_freq_hz=32'hFFFF_FFFF, o_div_zero=1, o_freq_valid 1 cycle after capture.
REQ-041 With local=1 and extern=100 -> P=10^10 >= 2^32, so o_saturated=1 and o_freq_hz=32'hFFFF_FFFF.
REQ-042 Upstream valid never returning, TIMEOUT_CYCLES=50 -> o_timeout=1 at cycle 50, no latch pulse until i_enable toggles 0 then 1.
REQ-043 i_freq_ready held 0 for 20 cycles -> o_freq_hz stable, no o_latch_counters pulse, GATE entered the cycle after the handshake.
REQ-044 i_enable dropped during GATE=5 with GATE_CYCLES=10 -> IDLE next cycle, no latch pulse; dropped in WAIT_VALID -> IDLE only after valid returns.
